mem_arbiter: RTL

Single-port memory arbiter that shares one RAM port between the instruction-fetch path and the data path of the single-cycle MIPS core. It accepts the fetch request and the load/store request generated from the control unit's `dread`/`dwrite`, grants one at a time with data priority, drives the RAM port through a registered FSM, and returns a one-cycle completion strobe with the returned word. It also honours the control unit's `halt` by draining and then freezing the port, and flags RAM timeouts.

---
 rtl/mem_arbiter.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port RAM between instruction fetch and data
// load/store (data first), with a halt drain/freeze and an access timeout.
module mem_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int WORD_W  = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  input  logic              halt,
  input  logic [WORD_W-1:0] ramload,
  input  logic              ramready,
  output logic              iwait,
  output logic              dwait,
  output logic [WORD_W-1:0] iload,
  output logic [WORD_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  output logic              halted,
  output logic              err
);

  // Handshake: a requester holds its request (and address/data) high until it
  // sees its wait low for one cycle; the RAM completes an access by raising
  // ramready for one cycle while an enable is high. Requests seen during the
  // completion cycle are ignored so a still-held request is not serviced twice.

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    IACC   = 3'd1,
    DACC   = 3'd2,
    DONE   = 3'd3,
    HALTED = 3'd4
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              write_q;
  logic              halt_seen_q;
  logic              iwait_q;
  logic              dwait_q;
  logic [WORD_W-1:0] iload_q;
  logic [WORD_W-1:0] dload_q;
  logic              ramren_q;
  logic              ramwen_q;
  logic [WORD_W-1:0] ramaddr_q;
  logic [WORD_W-1:0] ramstore_q;
  logic              halted_q;
  logic              err_q;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      halt_seen_q <= 1'b0;
      iwait_q     <= 1'b1;
      dwait_q     <= 1'b1;
      iload_q     <= '0;
      dload_q     <= '0;
      ramren_q    <= 1'b0;
      ramwen_q    <= 1'b0;
      ramaddr_q   <= '0;
      ramstore_q  <= '0;
      halted_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          iwait_q     <= 1'b1;
          dwait_q     <= 1'b1;
          halt_seen_q <= 1'b0;
          cnt_q       <= '0;
          if (halt) begin
            state_q  <= HALTED;
            halted_q <= 1'b1;
          end else if (dREN || dWEN) begin
            // Simultaneous read and write is illegal; it is serviced as a write.
            state_q    <= DACC;
            write_q    <= dWEN;
            ramaddr_q  <= daddr;
            ramstore_q <= dstore;
            ramren_q   <= ~dWEN;
            ramwen_q   <= dWEN;
            if (dREN && dWEN) begin
              err_q <= 1'b1;
            end
          end else if (iREN) begin
            state_q   <= IACC;
            write_q   <= 1'b0;
            ramaddr_q <= iaddr;
            ramren_q  <= 1'b1;
            ramwen_q  <= 1'b0;
          end
        end

        IACC, DACC: begin
          if (halt) begin
            halt_seen_q <= 1'b1;
          end
          if (ramready) begin
            state_q  <= DONE;
            ramren_q <= 1'b0;
            ramwen_q <= 1'b0;
            if (state_q == IACC) begin
              iload_q <= ramload;
              iwait_q <= 1'b0;
            end else begin
              if (!write_q) begin
                dload_q <= ramload;
              end
              dwait_q <= 1'b0;
            end
          end else if (cnt_q == CNT_LAST) begin
            // Abandoned access: reads return zero and the error flag sticks.
            state_q  <= DONE;
            ramren_q <= 1'b0;
            ramwen_q <= 1'b0;
            err_q    <= 1'b1;
            if (state_q == IACC) begin
              iload_q <= '0;
              iwait_q <= 1'b0;
            end else begin
              if (!write_q) begin
                dload_q <= '0;
              end
              dwait_q <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        DONE: begin
          iwait_q <= 1'b1;
          dwait_q <= 1'b1;
          if (halt || halt_seen_q) begin
            state_q  <= HALTED;
            halted_q <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end

        HALTED: begin
          halted_q <= 1'b1;
          iwait_q  <= 1'b1;
          dwait_q  <= 1'b1;
          ramren_q <= 1'b0;
          ramwen_q <= 1'b0;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign iwait    = iwait_q;
  assign dwait    = dwait_q;
  assign iload    = iload_q;
  assign dload    = dload_q;
  assign ramREN   = ramren_q;
  assign ramWEN   = ramwen_q;
  assign ramaddr  = ramaddr_q;
  assign ramstore = ramstore_q;
  assign halted   = halted_q;
  assign err      = err_q;

endmodule
